// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin count, one-hot coin codes,
// FSM state encodings and default coin values.
package change_dispenser_pkg;

  localparam int unsigned NumCoins = 3;

  typedef logic [NumCoins-1:0] coin_oh_t;
  typedef logic [2:0]          state_t;

  localparam coin_oh_t CoinNone = 3'b000;
  localparam coin_oh_t CoinOh0  = 3'b001;
  localparam coin_oh_t CoinOh1  = 3'b010;
  localparam coin_oh_t CoinOh2  = 3'b100;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StSelect = 3'd1;
  localparam state_t StPulse  = 3'd2;
  localparam state_t StGap    = 3'd3;
  localparam state_t StDone   = 3'd4;

  localparam int unsigned DefCoin0Value = 100;
  localparam int unsigned DefCoin1Value = 500;
  localparam int unsigned DefCoin2Value = 1000;
  localparam int unsigned DefStockW     = 8;
  localparam int unsigned DefInitStock  = 10;
  localparam int unsigned DefGapCycles  = 2;

  // Value of a one-hot coin code; zero for an empty code.
  function automatic logic [31:0] coin_value(input coin_oh_t    oh,
                                             input logic [31:0] v0,
                                             input logic [31:0] v1,
                                             input logic [31:0] v2);
    logic [31:0] val;
    val = '0;
    if (oh[0]) val = v0;
    if (oh[1]) val = v1;
    if (oh[2]) val = v2;
    return val;
  endfunction

endpackage

// File: rtl/change_dispenser_stock.sv
// Per-coin stock counter: saturating increment on refill, floor-at-zero decrement on dispense.
module coin_stock_counter #(
  parameter int unsigned StockW    = 8,
  parameter int unsigned InitStock = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic empty_o
);

  localparam logic [StockW-1:0] MaxCount = '1;
  localparam logic [StockW-1:0] InitVal  = StockW'(InitStock);

  logic [StockW-1:0] count_q, count_d;

  // Simultaneous refill and dispense cancel out.
  always_comb begin
    count_d = count_q;
    unique case ({inc_i, dec_i})
      2'b10: if (count_q != MaxCount) count_d = count_q + StockW'(1);
      2'b01: if (count_q != '0)       count_d = count_q - StockW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= InitVal;
    end else begin
      count_q <= count_d;
    end
  end

  assign empty_o = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: turns a change amount into spaced one-hot coin pulses,
// tracking per-coin stock and reporting whatever could not be paid out.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned COIN0_VALUE = DefCoin0Value,
  parameter int unsigned COIN1_VALUE = DefCoin1Value,
  parameter int unsigned COIN2_VALUE = DefCoin2Value,
  parameter int unsigned STOCK_W     = DefStockW,
  parameter int unsigned INIT_STOCK  = DefInitStock,
  parameter int unsigned GAP_CYCLES  = DefGapCycles
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_amount,
  input  logic [2:0]  i_refill_coin,
  output logic        o_ready,
  output logic [2:0]  o_return_coin,
  output logic        o_done,
  output logic [31:0] o_remainder,
  output logic [2:0]  o_stock_empty
);

  localparam logic [31:0] Coin0Val = 32'(COIN0_VALUE);
  localparam logic [31:0] Coin1Val = 32'(COIN1_VALUE);
  localparam logic [31:0] Coin2Val = 32'(COIN2_VALUE);

  localparam int unsigned    GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLoad = (GAP_CYCLES > 0) ? GapW'(GAP_CYCLES - 1) : '0;

  state_t          state_q, state_d;
  logic [31:0]     rem_q, rem_d;
  logic [31:0]     remainder_q, remainder_d;
  coin_oh_t        sel_q, sel_d;
  logic [GapW-1:0] gap_q, gap_d;

  coin_oh_t stock_empty;
  coin_oh_t dec_coin;
  coin_oh_t pick;

  for (genvar k = 0; k < NumCoins; k++) begin : g_stock
    coin_stock_counter #(
      .StockW    (STOCK_W),
      .InitStock (INIT_STOCK)
    ) u_stock (
      .clk_i   (clk),
      .rst_i   (reset),
      .inc_i   (i_refill_coin[k]),
      .dec_i   (dec_coin[k]),
      .empty_o (stock_empty[k])
    );
  end

  // Largest coin that fits in the remaining amount and is still in stock.
  always_comb begin
    pick = CoinNone;
    if (rem_q >= Coin2Val && !stock_empty[2]) begin
      pick = CoinOh2;
    end else if (rem_q >= Coin1Val && !stock_empty[1]) begin
      pick = CoinOh1;
    end else if (rem_q >= Coin0Val && !stock_empty[0]) begin
      pick = CoinOh0;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    remainder_d = remainder_q;
    sel_d       = sel_q;
    gap_d       = gap_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          rem_d   = i_amount;
          state_d = StSelect;
        end
      end
      StSelect: begin
        if (pick != CoinNone) begin
          sel_d   = pick;
          state_d = StPulse;
        end else begin
          // Latch on entry so the remainder is already valid alongside o_done.
          remainder_d = rem_q;
          state_d     = StDone;
        end
      end
      StPulse: begin
        rem_d = rem_q - coin_value(sel_q, Coin0Val, Coin1Val, Coin2Val);
        if (GAP_CYCLES == 0) begin
          state_d = StSelect;
        end else begin
          gap_d   = GapLoad;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StSelect;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      remainder_q <= '0;
      sel_q       <= CoinNone;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      remainder_q <= remainder_d;
      sel_q       <= sel_d;
      gap_q       <= gap_d;
    end
  end

  assign dec_coin      = (state_q == StPulse) ? sel_q : CoinNone;
  assign o_ready       = (state_q == StIdle);
  assign o_return_coin = dec_coin;
  assign o_done        = (state_q == StDone);
  assign o_remainder   = remainder_q;
  assign o_stock_empty = stock_empty;

endmodule
